display_scan_scheduler: RTL and testbench

//   Time-multiplexes NDIG hex digits onto one shared, active-low 7-segment bus for the calculator display.

---
 rtl/display_scan_scheduler_pkg.sv | 18 +
 rtl/display_scan_scheduler_if.sv | 25 ++
 rtl/display_scan_scheduler_decode.sv | 11 +
 rtl/display_scan_scheduler.sv | 141 ++++++++++++++
 tb/tb_display_scan_scheduler.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/display_scan_scheduler_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value 0..F
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Display scanner bus: controls and digit inputs in, segment/anode pins and status out.
interface display_scan_scheduler_if #(
  parameter int NDIG = 4
) ();

  logic                    en;
  logic [4*NDIG-1:0]       digit_data;
  logic [NDIG-1:0]         dp_in;
  logic [NDIG-1:0]         anode;
  logic [6:0]              seg;
  logic                    dp;
  logic [$clog2(NDIG)-1:0] digit_idx;
  logic                    frame_done;

  modport master (
    output en, digit_data, dp_in,
    input  anode, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  en, digit_data, dp_in,
    output anode, seg, dp, digit_idx, frame_done
  );

endinterface

// File: rtl/display_scan_scheduler_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg_decode
  import display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_FONT[i_nibble];

endmodule

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed hex display scanner with clock-enable slot divider.
// Optional inter-digit blanking is built when SCAN_BLANK_EN is defined.
module display_scan_scheduler
  import display_pkg::*;
#(
  parameter int NDIG      = 4,
  parameter int DIV       = 5000,
  parameter int BLANK_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  display_scan_scheduler_if.slave  bus
);

  localparam int IW = $clog2(NDIG);
  localparam int DW = $clog2(DIV);

  if (NDIG < 2 || NDIG > 8) begin : g_bad_ndig
    $error("NDIG out of range");
  end
  if (DIV < 2 || BLANK_CYC < 1 || BLANK_CYC >= DIV) begin : g_bad_timing
    $error("DIV/BLANK_CYC out of range");
  end

  scan_state_t     r_state, w_state_nx;
  logic [DW-1:0]   r_div_cnt, w_div_nx;
  logic [IW-1:0]   r_digit_idx, w_idx_nx;
  logic            w_tick, w_last, w_frame_nx;
  logic [3:0]      w_nibble;
  logic [6:0]      w_seg;
  logic [NDIG-1:0] r_anode;
  logic [6:0]      r_seg;
  logic            r_dp, r_frame_done;

`ifdef SCAN_BLANK_EN
  localparam int BW = $clog2(BLANK_CYC + 1);
  logic [BW-1:0]   r_blank_cnt, w_blank_nx;
`endif

  assign w_tick = (r_state == DRIVE) && (r_div_cnt == DW'(DIV - 1));
  assign w_last = (r_digit_idx == IW'(NDIG - 1));

  always_comb begin
    w_state_nx = r_state;
    w_div_nx   = r_div_cnt;
    w_idx_nx   = r_digit_idx;
    w_frame_nx = 1'b0;
`ifdef SCAN_BLANK_EN
    w_blank_nx = r_blank_cnt;
`endif
    // Dropping en beats a pending tick and restarts the scan from digit 0
    if (!bus.en) begin
      w_state_nx = IDLE;
      w_div_nx   = '0;
      w_idx_nx   = '0;
`ifdef SCAN_BLANK_EN
      w_blank_nx = '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nx = DRIVE;
          w_div_nx   = '0;
          w_idx_nx   = '0;
        end
        DRIVE: begin
          if (w_tick) begin
            w_div_nx   = '0;
            w_idx_nx   = w_last ? '0 : r_digit_idx + 1'b1;
            w_frame_nx = w_last;
`ifdef SCAN_BLANK_EN
            w_state_nx = BLANK;
            w_blank_nx = '0;
`endif
          end else begin
            w_div_nx = r_div_cnt + 1'b1;
          end
        end
`ifdef SCAN_BLANK_EN
        BLANK: begin
          if (r_blank_cnt == BW'(BLANK_CYC - 1)) begin
            w_state_nx = DRIVE;
            w_blank_nx = '0;
          end else begin
            w_blank_nx = r_blank_cnt + 1'b1;
          end
        end
`endif
        default: w_state_nx = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state so pins line up with the state register
  assign w_nibble = 4'(bus.digit_data >> {w_idx_nx, 2'b00});

  hex7seg_decode u_decode (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_div_cnt    <= '0;
      r_digit_idx  <= '0;
      r_anode      <= '1;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_div_cnt    <= w_div_nx;
      r_digit_idx  <= w_idx_nx;
      r_frame_done <= w_frame_nx;
      if (w_state_nx == DRIVE) begin
        r_anode <= ~(NDIG'(1) << w_idx_nx);
        r_seg   <= w_seg;
        r_dp    <= ~bus.dp_in[w_idx_nx];
      end else begin
        r_anode <= '1;
        r_seg   <= SEG_OFF;
        r_dp    <= 1'b1;
      end
    end
  end

`ifdef SCAN_BLANK_EN
  always_ff @(posedge clk) begin
    if (rst) r_blank_cnt <= '0;
    else     r_blank_cnt <= w_blank_nx;
  end
`endif

  assign bus.anode      = r_anode;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.digit_idx  = r_digit_idx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// Directed bench for display_scan_scheduler (NDIG=4, DIV=4, BLANK_CYC=2); follows SCAN_BLANK_EN.
module tb_display_scan_scheduler;

  localparam int NDIG = 4;
  localparam int DIV  = 4;
`ifdef SCAN_BLANK_EN
  localparam int BCYC = 2;
`else
  localparam int BCYC = 0;
`endif
  localparam int SLOT  = DIV + BCYC;
  localparam int FRAME = NDIG * SLOT;
  localparam int NVEC  = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  display_scan_scheduler_if #(.NDIG(NDIG)) bus ();

  display_scan_scheduler #(.NDIG(NDIG), .DIV(DIV), .BLANK_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  idx;
    logic        frame;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_dark(input string tag);
    chk({tag, " anode"}, int'(bus.anode), 'hF);
    chk({tag, " seg"},   int'(bus.seg), 'h7F);
    chk({tag, " dp"},    int'(bus.dp), 1);
    chk({tag, " idx"},   int'(bus.digit_idx), 0);
    chk({tag, " frame"}, int'(bus.frame_done), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] an_tab  [4];
    logic [6:0] seg_tab [4];
    an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30};

    // Expected waveform for one continuous scan starting the cycle after reset release
    for (int k = 0; k < NVEC; k++) begin
      int p, d, o;
      p = k % FRAME;
      d = p / SLOT;
      o = p % SLOT;
      vecs[k].en    = 1'b1;
      vecs[k].data  = 16'h3210;
      vecs[k].dp_in = 4'b0100;
      if (o < DIV) begin
        vecs[k].anode = an_tab[d];
        vecs[k].seg   = seg_tab[d];
        vecs[k].dp    = (d == 2) ? 1'b0 : 1'b1;
        vecs[k].idx   = 2'(d);
      end else begin
        vecs[k].anode = 4'hF;
        vecs[k].seg   = 7'h7F;
        vecs[k].dp    = 1'b1;
        vecs[k].idx   = 2'((d + 1) % NDIG);
      end
      vecs[k].frame = (k > 0) && (((k + BCYC) % FRAME) == 0);
    end

    bus.en = 1'b1;
    bus.digit_data = 16'h3210;
    bus.dp_in = 4'b0100;

    // Reset held with en=1
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_dark("reset");
    end
    rst = 1'b0;

    for (int k = 0; k < NVEC; k++) begin
      bus.en = vecs[k].en;
      bus.digit_data = vecs[k].data;
      bus.dp_in = vecs[k].dp_in;
      step();
      chk($sformatf("scan[%0d] anode", k), int'(bus.anode), int'(vecs[k].anode));
      chk($sformatf("scan[%0d] seg", k),   int'(bus.seg),   int'(vecs[k].seg));
      chk($sformatf("scan[%0d] dp", k),    int'(bus.dp),    int'(vecs[k].dp));
      chk($sformatf("scan[%0d] idx", k),   int'(bus.digit_idx), int'(vecs[k].idx));
      chk($sformatf("scan[%0d] frame", k), int'(bus.frame_done), int'(vecs[k].frame));
    end

    // Data change mid-slot shows up on seg one cycle later
    do_reset();
    bus.digit_data = 16'h3210;
    step();
    step();
    chk("datachg before", int'(bus.seg), 'h40);
    bus.digit_data = 16'hFFFF;
    step();
    chk("datachg after", int'(bus.seg), 'h0E);
    chk("datachg anode", int'(bus.anode), 'hE);
    bus.digit_data = 16'h3210;

    // en pulsed low mid-slot of digit 2, then full 4-cycle slot on digit 0
    do_reset();
    for (int k = 0; k <= 2 * SLOT + 1; k++) step();
    chk("en_drop pre anode", int'(bus.anode), 'hB);
    bus.en = 1'b0;
    step();
    chk_dark("en_drop idle");
    bus.en = 1'b1;
    for (int i = 0; i < DIV; i++) begin
      step();
      chk($sformatf("restart[%0d] anode", i), int'(bus.anode), 'hE);
      chk($sformatf("restart[%0d] idx", i), int'(bus.digit_idx), 0);
    end
    step();
    chk("restart next anode", int'(bus.anode), (BCYC > 0) ? 'hF : 'hD);
    chk("restart next idx", int'(bus.digit_idx), 1);

    // Reset on the cycle that would raise frame_done
    do_reset();
    for (int k = 0; k <= FRAME - BCYC - 1; k++) step();
    chk("prewrap idx", int'(bus.digit_idx), 3);
    rst = 1'b1;
    step();
    chk_dark("rst at wrap");
    rst = 1'b0;

    // Reset at slot offset DIV (inside BLANK when blanking is built)
    step();
    for (int k = 1; k <= DIV; k++) step();
    chk("mid pre idx", int'(bus.digit_idx), 1);
    chk("mid pre anode", int'(bus.anode), (BCYC > 0) ? 'hF : 'hD);
    rst = 1'b1;
    step();
    chk_dark("rst mid");
    rst = 1'b0;
    step();
    chk("post rst anode", int'(bus.anode), 'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
